// File: rtl/ser.sv
// Parallel-to-serial transmitter, MSB first; first bit appears the cycle after acceptance.
// One-word holding register keeps words back-to-back; in_ready drops only while it is occupied.
module ser #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out,
  output logic         out_valid,
  output logic         last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_shift;
  logic [N-1:0]   r_hold;
  logic [CW-1:0]  r_cnt;
  logic           r_hold_full;
  logic           w_xfer;
  logic           w_eow;

  assign in_ready = !r_hold_full;
  assign w_xfer   = in_valid && !r_hold_full;
  assign w_eow    = (r_state == SHIFT) && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next = SHIFT;
      SHIFT:   if (w_eow && !r_hold_full && !w_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The shift register drains to zero by the time IDLE is reached, so out needs no gating.
  always_comb begin
    out_valid = (r_state == SHIFT);
    last      = w_eow;
    out       = r_shift[N-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shift <= in_data;
            r_cnt   <= CNT_MAX;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_shift <= {r_shift[N-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
            if (w_xfer) begin
              r_hold      <= in_data;
              r_hold_full <= 1'b1;
            end
          end else if (r_hold_full) begin
            r_shift     <= r_hold;
            r_cnt       <= CNT_MAX;
            r_hold_full <= w_xfer;
            if (w_xfer) r_hold <= in_data;
          end else if (w_xfer) begin
            r_shift <= in_data;
            r_cnt   <= CNT_MAX;
          end else begin
            r_shift <= {r_shift[N-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ser.sv
// Directed bench for ser at N=8 and N=4, with an inline deserializer for loopback.
module tb_ser;

  logic       clk;
  logic       reset;
  logic       v8, rdy8, o8, ov8, l8;
  logic [7:0] d8;
  logic       v4, rdy4, o4, ov4, l4;
  logic [3:0] d4;
  logic [7:0] des_sr;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] s, v, l, rv;
  logic [31:0] s4, vs4, ls4;
  logic        acc;

  ser #(.N(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
    .out(o8), .out_valid(ov8), .last(l8)
  );

  ser #(.N(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out(o4), .out_valid(ov4), .last(l4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference deserializer in lock-step with ser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    des_sr <= '0;
    else if (ov8) des_sr <= {des_sr[6:0], o8};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    s = '0; v = '0; l = '0;
  endtask

  task automatic cap8();
    s = {s[30:0], o8};
    v = {v[30:0], ov8};
    l = {l[30:0], l8};
  endtask

  task automatic cap4();
    s4  = {s4[30:0], o4};
    vs4 = {vs4[30:0], ov4};
    ls4 = {ls4[30:0], l4};
  endtask

  initial begin
    reset = 1'b1; v8 = 1'b0; d8 = '0; v4 = 1'b0; d4 = '0;
    #12;
    chk("rst_ready", 32'(rdy8), 32'd1);
    chk("rst_valid", 32'(ov8), 32'd0);
    chk("rst_out", 32'(o8), 32'd0);
    chk("rst_last", 32'(l8), 32'd0);
    reset = 1'b0;
    step();

    // Single word
    v8 = 1'b1; d8 = 8'hA5;
    step();
    v8 = 1'b0; d8 = 8'hFF;
    clr();
    for (int c = 1; c <= 8; c++) begin cap8(); step(); end
    chk("a5_bits", s, 32'hA5);
    chk("a5_valid", v, 32'hFF);
    chk("a5_last", l, 32'h01);
    chk("a5_idle_vld", 32'(ov8), 32'd0);
    chk("a5_idle_out", 32'(o8), 32'd0);

    // Back-to-back through the holding register
    v8 = 1'b1; d8 = 8'hF0;
    step();
    chk("b2b_rdy1", 32'(rdy8), 32'd1);
    d8 = 8'h0F;
    clr(); cap8();
    step();
    v8 = 1'b0;
    chk("b2b_rdy2", 32'(rdy8), 32'd0);
    for (int c = 2; c <= 16; c++) begin cap8(); step(); end
    chk("b2b_bits", s, 32'hF00F);
    chk("b2b_valid", v, 32'hFFFF);
    chk("b2b_last", l, 32'h0101);
    chk("b2b_idle", 32'(ov8), 32'd0);

    // Backpressure with three words offered continuously
    v8 = 1'b1; d8 = 8'h01;
    step();
    d8 = 8'h02;
    clr(); cap8();
    step();
    d8 = 8'h03; rv = '0;
    for (int c = 2; c <= 24; c++) begin
      cap8();
      rv  = {rv[30:0], rdy8};
      acc = rdy8;
      step();
      if (acc) v8 = 1'b0;
    end
    chk("bp_bits", s, 32'h010203);
    chk("bp_valid", v, 32'hFFFFFF);
    chk("bp_last", l, 32'h010101);
    chk("bp_ready", rv, 32'h0080FF);
    chk("bp_idle", 32'(ov8), 32'd0);

    // Reset mid-word, with a second word sitting in hold
    v8 = 1'b1; d8 = 8'hFF;
    step();
    d8 = 8'hAA;
    step();
    v8 = 1'b0;
    step();
    step();
    chk("mid_pre_vld", 32'(ov8), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid_out", 32'(o8), 32'd0);
    chk("mid_vld", 32'(ov8), 32'd0);
    chk("mid_rdy", 32'(rdy8), 32'd1);
    chk("mid_last", 32'(l8), 32'd0);
    #2 reset = 1'b0;
    clr();
    for (int c = 0; c < 3; c++) begin step(); cap8(); end
    chk("mid_no_resume", v, 32'h0);
    v8 = 1'b1; d8 = 8'h3C;
    step();
    v8 = 1'b0;
    clr();
    for (int c = 1; c <= 8; c++) begin cap8(); step(); end
    chk("mid_3c_bits", s, 32'h3C);
    chk("mid_3c_valid", v, 32'hFF);
    chk("mid_3c_idle", 32'(ov8), 32'd0);

    // Loopback into the reference deserializer
    v8 = 1'b1; d8 = 8'h78;
    step();
    v8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) chk("lb_last", 32'(l8), 32'd1);
      step();
    end
    chk("lb_des", 32'(des_sr), 32'h78);

    // New word offered only on the final-bit cycle loads directly
    v8 = 1'b1; d8 = 8'h81;
    step();
    v8 = 1'b0;
    clr();
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) begin v8 = 1'b1; d8 = 8'h42; end
      cap8();
      step();
      if (c == 8) v8 = 1'b0;
    end
    chk("eow_bits", s, 32'h8142);
    chk("eow_valid", v, 32'hFFFF);
    chk("eow_idle", 32'(ov8), 32'd0);

    // N=4 back-to-back
    v4 = 1'b1; d4 = 4'h9;
    step();
    d4 = 4'h6;
    s4 = '0; vs4 = '0; ls4 = '0;
    cap4();
    step();
    v4 = 1'b0;
    for (int c = 2; c <= 8; c++) begin cap4(); step(); end
    chk("n4_bits", s4, 32'h96);
    chk("n4_valid", vs4, 32'hFF);
    chk("n4_last", ls4, 32'h11);
    chk("n4_idle", 32'(ov4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ser.md
Name: ser

Overview:
Parallel-to-serial transmitter, the transmit-side counterpart of the des deserializer.
- Accepts N-bit words through a valid/ready handshake.
- Shifts each word out one bit per clock, MSB first, so a des instance clocked in lock-step reconstructs the word after N cycles.
- A one-word holding register allows back-to-back words with no idle cycle between them.

Parameters:
N, 8, word width in bits (N >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a word to send
in_data  input  N  parallel word, sampled when in_valid && in_ready at a rising edge
in_ready  output  1  block can accept a word this cycle
out  output  1  serial bit stream, MSB first
out_valid  output  1  out carries a data bit this cycle
last  output  1  high with the final (LSB) bit of each word

Behaviour:
- Reset is asynchronous, active-high, and forces the state immediately:
  - out=0, out_valid=0, last=0, in_ready=1.
  - Shift register cleared, bit counter=0, holding register empty, FSM in IDLE.
  - Any word in flight or held is discarded; no partial word resumes after reset.
- Handshake:
  - A transfer occurs on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = !hold_full. It is decoded from registered state only, with no combinational path from in_valid.
  - in_data is ignored when in_valid=0.
- FSM states: IDLE and SHIFT.
- IDLE:
  - out_valid=0, out=0, last=0.
  - On a transfer, the word loads directly into the shift register and counter=N-1, then go to SHIFT.
  - Latency: out=in_data[N-1] with out_valid=1 on the first cycle after the accepting edge.
- SHIFT:
  - Each cycle: out=shift[N-1] and out_valid=1.
  - On each edge: shift left by one, counter decrements.
  - last=1 exactly when counter=0, i.e. the bit out equals the original in_data[0].
- Transfer while in SHIFT: the word goes to the holding register (hold_full=1), so in_ready=0 from the next cycle.
- End-of-word edge (counter=0), in priority order:
  - (a) hold_full=1: load the held word into the shift register, counter=N-1, clear hold_full, stay in SHIFT.
  - (b) hold empty and a transfer occurs on this same edge: load the incoming word directly into the shift register and stay in SHIFT.
  - (c) otherwise: go to IDLE; out_valid=0 on the next cycle.
  - Cases (a) and (b) keep out_valid continuously high, with no gap bit.
- Simultaneous events:
  - If a transfer happens on the same edge that case (a) drains hold, the new word enters hold. No loss and no duplication.
  - A hold_full word is always sent in acceptance order after the current word.
- Throughput: sustained 1 word per N cycles. in_ready may be low for up to N-1 cycles per word.
- Widths: the counter is ceil(log2(N)) bits and never wraps below 0. Behaviour is identical for any N >= 2.
- Output encoding: out is registered (no combinational glitching). out is 0 whenever out_valid=0.

Test Plan:
- Single word: N=8, reset, then in_data=8'hA5 accepted at edge 0 -> cycles 1..8: out=1,0,1,0,0,1,0,1; out_valid=1 on cycles 1..8; last=1 only on cycle 8; cycle 9: out_valid=0, out=0.
- Back-to-back: 8'hF0 accepted, then 8'h0F presented with in_valid held high -> in_ready drops the cycle after 8'h0F is held; 16 contiguous out_valid cycles; out = 11110000 00001111; last on bits 8 and 16.
- Backpressure: 8'h01, 8'h02, 8'h03 offered continuously -> 8'h03 waits (in_ready=0) until the cycle after the first word's last bit; all 24 bits sent in order with no gaps and no drops.
- Reset mid-word: 8'hFF accepted, reset asserted asynchronously after 3 bits -> out=0, out_valid=0, in_ready=1 immediately; after release, 8'h3C sends cleanly as 00111100 with no leftover 1s.
- Loopback: ser.out drives des.in, same clk and reset, 8'h78 sent -> the des output equals 8'h78 on the cycle after ser's last=1.
- Width: N=4, words 4'h9 then 4'h6 back-to-back -> out = 1001 0110, last every 4th bit, out_valid continuous for 8 cycles.
